jcs_decoder: RTL

//  Receive-side companion of the N-bit Johnson (twisted-ring) counter. Samples a

---
 rtl/jcs_decoder_if.sv | 32 +++
 rtl/jcs_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jcs_decoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jcs_decoder_if : sample/status bundle for the Johnson-code decoder
// Rev 1.0
// ----------------------------------------------------------------------------
interface jcs_decoder_if #(
  parameter int N     = 4,
  parameter int ERR_W = 8
);
  localparam int IDXW = $clog2(2*N);

  logic             en;
  logic [N-1:0]     jc;
  logic             err_clr;
  logic             valid_code;
  logic [IDXW-1:0]  idx;
  logic             locked;
  logic             seq_err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, jc, err_clr,
    input  valid_code, idx, locked, seq_err, wrap, err_cnt
  );

  modport slave (
    input  en, jc, err_clr,
    output valid_code, idx, locked, seq_err, wrap, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/jcs_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jcs_decoder : Johnson-code position decoder with lock tracking and error count
// Rev 1.0
// ----------------------------------------------------------------------------
module jcs_decoder #(
  parameter int N        = 4,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic         clk,
  input  logic         clr,
  jcs_decoder_if.slave jcs
);
  localparam int IDXW = $clog2(2*N);
  localparam logic [IDXW-1:0]  c_last_idx = IDXW'(2*N-1);
  localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] c_err_max  = '1;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_prev;
  logic [3:0]       r_run;
  logic [IDXW-1:0]  r_idx;
  logic             r_valid;
  logic             r_seq_err;
  logic             r_wrap;
  logic [ERR_W-1:0] r_err_cnt;

  state_t           w_state_nxt;
  logic [IDXW-1:0]  w_prev_nxt;
  logic [3:0]       w_run_nxt;
  logic             w_seq_err_nxt;
  logic             w_wrap_nxt;
  logic             w_legal;
  logic [IDXW-1:0]  w_idx;
  logic [IDXW-1:0]  w_succ;
  logic             w_is_succ;
  logic             w_is_stall;

  // Position k: low k bits set for k<=N, otherwise bits k-N..N-1 set.
  function automatic logic [N-1:0] f_pattern(input int k);
    logic [N-1:0] p;
    p = '0;
    for (int b = 0; b < N; b++) begin
      p[b] = (k <= N) ? (b < k) : (b >= k - N);
    end
    return p;
  endfunction

  always_comb begin
    w_legal = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (jcs.jc == f_pattern(k)) begin
        w_legal = 1'b1;
        w_idx   = IDXW'(k);
      end
    end
  end

  assign w_succ     = (r_prev == c_last_idx) ? '0 : r_prev + 1'b1;
  assign w_is_succ  = (w_idx == w_succ);
  assign w_is_stall = (w_idx == r_prev);

  always_comb begin
    w_state_nxt   = r_state;
    w_prev_nxt    = r_prev;
    w_run_nxt     = r_run;
    w_seq_err_nxt = 1'b0;
    w_wrap_nxt    = 1'b0;
    if (jcs.en) begin
      case (r_state)
        ST_UNSYNC: begin
          if (w_legal) begin
            w_state_nxt = ST_TRACK;
            w_prev_nxt  = w_idx;
            w_run_nxt   = 4'd0;
          end
        end
        ST_TRACK: begin
          if (!w_legal) begin
            w_state_nxt = ST_UNSYNC;
            w_run_nxt   = 4'd0;
          end else if (w_is_succ) begin
            w_prev_nxt = w_idx;
            w_run_nxt  = r_run + 4'd1;
            if (r_run + 4'd1 == c_lock_cnt) begin
              w_state_nxt = ST_LOCKED;
            end
          end else if (!w_is_stall) begin
            w_prev_nxt = w_idx;
            w_run_nxt  = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!w_legal) begin
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = ST_UNSYNC;
            w_run_nxt     = 4'd0;
          end else if (w_is_succ) begin
            w_prev_nxt = w_idx;
            w_wrap_nxt = (r_prev == c_last_idx);
          end else if (!w_is_stall) begin
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = ST_TRACK;
            w_run_nxt     = 4'd0;
            w_prev_nxt    = w_idx;
          end
        end
        default: begin
          w_state_nxt = ST_UNSYNC;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_UNSYNC;
      r_prev    <= '0;
      r_run     <= 4'd0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_seq_err <= 1'b0;
      r_wrap    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_prev_nxt;
      r_run     <= w_run_nxt;
      r_seq_err <= w_seq_err_nxt;
      r_wrap    <= w_wrap_nxt;
      if (jcs.en) begin
        r_valid <= w_legal;
        if (w_legal) begin
          r_idx <= w_idx;
        end
      end
      // Clear beats a coincident error increment.
      if (jcs.err_clr) begin
        r_err_cnt <= '0;
      end else if (w_seq_err_nxt && (r_err_cnt != c_err_max)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign jcs.valid_code = r_valid;
  assign jcs.idx        = r_idx;
  assign jcs.locked     = (r_state == ST_LOCKED);
  assign jcs.seq_err    = r_seq_err;
  assign jcs.wrap       = r_wrap;
  assign jcs.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
